// File: rtl/etb_tim_trig_route.sv
// ----------------------------------------------------------------------------
// etb_tim_trig_route
// Event-trigger routing stage in front of the timer block. Four APB-programmed
// channels each map one source trigger edge (or a software trigger) to a
// one-cycle start (trig_en_on) or stop (trig_en_off) pulse on one of four
// destinations. Pending/collision status is W1C and drives a level interrupt.
// ----------------------------------------------------------------------------
module etb_tim_trig_route #(
  parameter int NUM_SRC  = 8,
  parameter int SYNC_SRC = 0
) (
  input  logic               pclk,
  input  logic               preset,
  input  logic               psel,
  input  logic               penable,
  input  logic               pwrite,
  input  logic [31:0]        paddr,
  input  logic [31:0]        pwdata,
  output logic [31:0]        prdata,
  input  logic [NUM_SRC-1:0] src_trig,
  output logic [3:0]         trig_en_on,
  output logic [3:0]         trig_en_off,
  output logic               intr
);

  // Register word index (paddr[5:2])
  localparam logic [3:0] ADDR_CH0  = 4'd0;
  localparam logic [3:0] ADDR_CH1  = 4'd1;
  localparam logic [3:0] ADDR_CH2  = 4'd2;
  localparam logic [3:0] ADDR_CH3  = 4'd3;
  localparam logic [3:0] ADDR_SOFT = 4'd4;
  localparam logic [3:0] ADDR_STAT = 4'd5;

  // Pack the stored channel fields into their register layout; all other
  // bits read as zero.
  function automatic logic [31:0] f_pack_cfg(
    input logic       en,
    input logic       mode,
    input logic [2:0] src,
    input logic [1:0] dst,
    input logic       ien
  );
    logic [31:0] v;
    v        = 32'h0000_0000;
    v[0]     = en;
    v[1]     = mode;
    v[6:4]   = src;
    v[9:8]   = dst;
    v[16]    = ien;
    return v;
  endfunction

  // ---------------------------------------------------------------------------
  // Channel configuration and status state
  // ---------------------------------------------------------------------------
  logic       r_en   [4];
  logic       r_mode [4];
  logic [2:0] r_src  [4];
  logic [1:0] r_dst  [4];
  logic       r_ien  [4];
  logic [3:0] r_pend;
  logic [3:0] r_coll;
  logic [NUM_SRC-1:0] r_src_q;

  // ---------------------------------------------------------------------------
  // APB decode
  // ---------------------------------------------------------------------------
  logic       w_wr;
  logic [3:0] w_idx;
  logic [3:0] w_cfg_we;
  logic [3:0] w_soft;
  logic [3:0] w_w1c_pend;
  logic [3:0] w_w1c_coll;
  logic       w_unused;

  assign w_wr     = psel & penable & pwrite;
  assign w_idx    = paddr[5:2];
  // Address bits outside the decoded window carry no meaning here.
  assign w_unused = ^{paddr[31:6], paddr[1:0]};

  // Decode a committed write into per-register strobes
  always_comb begin
    w_cfg_we   = 4'b0000;
    w_soft     = 4'b0000;
    w_w1c_pend = 4'b0000;
    w_w1c_coll = 4'b0000;
    if (w_wr) begin
      case (w_idx)
        ADDR_CH0, ADDR_CH1, ADDR_CH2, ADDR_CH3: w_cfg_we[w_idx[1:0]] = 1'b1;
        ADDR_SOFT: w_soft = pwdata[3:0];
        ADDR_STAT: begin
          w_w1c_pend = pwdata[3:0];
          w_w1c_coll = pwdata[11:8];
        end
        default: w_cfg_we = 4'b0000;
      endcase
    end else begin
      w_cfg_we = 4'b0000;
    end
  end

  // ---------------------------------------------------------------------------
  // Source conditioning and edge detection
  // ---------------------------------------------------------------------------
  logic [NUM_SRC-1:0] w_src;
  logic [NUM_SRC-1:0] w_edge;
  logic [7:0]         w_edge8;

  generate
    if (SYNC_SRC != 0) begin : g_sync
      logic [NUM_SRC-1:0] r_sync1;
      logic [NUM_SRC-1:0] r_sync2;
      // Two-flop synchronizer for sources from other clock domains
      always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
          r_sync1 <= '0;
          r_sync2 <= '0;
        end else begin
          r_sync1 <= src_trig;
          r_sync2 <= r_sync1;
        end
      end
      assign w_src = r_sync2;
    end else begin : g_nosync
      assign w_src = src_trig;
    end
  endgenerate

  // Edge history: a held level fires only on its first cycle
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      r_src_q <= '0;
    end else begin
      r_src_q <= w_src;
    end
  end

  assign w_edge = w_src & ~r_src_q;

  // Widen to 8 so any src_sel can index; selects past NUM_SRC never fire.
  generate
    for (genvar g = 0; g < 8; g++) begin : g_edge8
      if (g < NUM_SRC) begin : g_real
        assign w_edge8[g] = w_edge[g];
      end else begin : g_zero
        assign w_edge8[g] = 1'b0;
      end
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Channel firing and destination merge
  // ---------------------------------------------------------------------------
  logic [3:0] w_fire;
  logic [3:0] w_on_req;
  logic [3:0] w_off_req;
  logic [3:0] w_coll_set;
  logic [3:0] w_ien_vec;

  // Fire using the configuration held before this edge; merge per destination
  always_comb begin
    w_fire     = 4'b0000;
    w_on_req   = 4'b0000;
    w_off_req  = 4'b0000;
    w_coll_set = 4'b0000;
    w_ien_vec  = 4'b0000;
    for (int n = 0; n < 4; n++) begin
      w_fire[n]    = r_en[n] & (w_edge8[r_src[n]] | w_soft[n]);
      w_ien_vec[n] = r_ien[n];
    end
    for (int d = 0; d < 4; d++) begin
      for (int n = 0; n < 4; n++) begin
        w_on_req[d]  = w_on_req[d]  | (w_fire[n] & ~r_mode[n] & (r_dst[n] == 2'(d)));
        w_off_req[d] = w_off_req[d] | (w_fire[n] &  r_mode[n] & (r_dst[n] == 2'(d)));
      end
    end
    // An on-request loses to an off-request on the same destination
    for (int n = 0; n < 4; n++) begin
      w_coll_set[n] = w_fire[n] & ~r_mode[n] & w_off_req[r_dst[n]];
    end
  end

  // ---------------------------------------------------------------------------
  // Sequential state
  // ---------------------------------------------------------------------------

  // Channel configuration registers, loaded from APB writes
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      for (int n = 0; n < 4; n++) begin
        r_en[n]   <= 1'b0;
        r_mode[n] <= 1'b0;
        r_src[n]  <= 3'd0;
        r_dst[n]  <= 2'd0;
        r_ien[n]  <= 1'b0;
      end
    end else begin
      for (int n = 0; n < 4; n++) begin
        if (w_cfg_we[n]) begin
          r_en[n]   <= pwdata[0];
          r_mode[n] <= pwdata[1];
          r_src[n]  <= pwdata[6:4];
          r_dst[n]  <= pwdata[9:8];
          r_ien[n]  <= pwdata[16];
        end
      end
    end
  end

  // Pending/collision status: a new event beats a simultaneous W1C
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      r_pend <= 4'b0000;
      r_coll <= 4'b0000;
    end else begin
      r_pend <= (r_pend & ~w_w1c_pend) | w_fire;
      r_coll <= (r_coll & ~w_w1c_coll) | w_coll_set;
    end
  end

  // Registered one-cycle destination pulses and interrupt level
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      trig_en_on  <= 4'b0000;
      trig_en_off <= 4'b0000;
      intr        <= 1'b0;
    end else begin
      trig_en_on  <= w_on_req & ~w_off_req;
      trig_en_off <= w_off_req;
      intr        <= |(r_pend & w_ien_vec);
    end
  end

  // ---------------------------------------------------------------------------
  // APB read mux
  // ---------------------------------------------------------------------------
  logic [31:0] w_cfg_word [4];

  // Present each channel's stored fields in register layout
  always_comb begin
    for (int n = 0; n < 4; n++) begin
      w_cfg_word[n] = f_pack_cfg(r_en[n], r_mode[n], r_src[n], r_dst[n], r_ien[n]);
    end
  end

  // Combinational read data; SOFT_TRIG and unmapped addresses read zero
  always_comb begin
    prdata = 32'h0000_0000;
    if (psel & ~pwrite) begin
      case (w_idx)
        ADDR_CH0, ADDR_CH1, ADDR_CH2, ADDR_CH3: prdata = w_cfg_word[w_idx[1:0]];
        ADDR_STAT: prdata = {20'h0_0000, r_coll, 4'h0, r_pend};
        default:   prdata = 32'h0000_0000;
      endcase
    end else begin
      prdata = 32'h0000_0000;
    end
  end

endmodule

// File: tb/tb_etb_tim_trig_route.sv
// ----------------------------------------------------------------------------
// tb_etb_tim_trig_route
// Directed bench for the event-trigger router: configuration access, edge
// routing, on/off collision, level hold, software trigger, W1C priority,
// interrupt timing and asynchronous reset during a pulse.
// ----------------------------------------------------------------------------
module tb_etb_tim_trig_route;

  logic        pclk = 1'b0;
  logic        preset;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic [7:0]  src_trig;
  logic [3:0]  trig_en_on;
  logic [3:0]  trig_en_off;
  logic        intr;

  int          n_chk  = 0;
  int          n_fail = 0;
  logic [31:0] rd;

  etb_tim_trig_route #(.NUM_SRC(8), .SYNC_SRC(0)) dut (
    .pclk       (pclk),
    .preset     (preset),
    .psel       (psel),
    .penable    (penable),
    .pwrite     (pwrite),
    .paddr      (paddr),
    .pwdata     (pwdata),
    .prdata     (prdata),
    .src_trig   (src_trig),
    .trig_en_on (trig_en_on),
    .trig_en_off(trig_en_off),
    .intr       (intr)
  );

  // 100 MHz clock
  always #5 pclk = ~pclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Setup at a falling edge, access at the next, commit on the rising edge;
  // returns 1 time unit after the commit edge.
  task automatic apb_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge pclk);
    psel = 1'b1; pwrite = 1'b1; penable = 1'b0; paddr = a; pwdata = d;
    @(negedge pclk);
    penable = 1'b1;
    @(posedge pclk);
    #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [31:0] a, output logic [31:0] d);
    @(negedge pclk);
    psel = 1'b1; pwrite = 1'b0; penable = 1'b0; paddr = a;
    #1;
    d = prdata;
    psel = 1'b0;
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  initial begin
    preset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = 32'h0; pwdata = 32'h0; src_trig = 8'h00;

    // ---------------- reset state ----------------
    #3;
    chk("rst_on",   {28'h0, trig_en_on},  32'h0);
    chk("rst_off",  {28'h0, trig_en_off}, 32'h0);
    chk("rst_intr", {31'h0, intr},        32'h0);
    @(negedge pclk);
    preset = 1'b0;
    apb_read(32'h00, rd); chk("rst_ch0", rd, 32'h0);
    apb_read(32'h14, rd); chk("rst_stat", rd, 32'h0);

    // ---------------- register access ----------------
    apb_write(32'h0C, 32'hFFFF_FFFF);
    apb_read(32'h0C, rd); chk("ch3_raz", rd, 32'h0001_0373);
    apb_write(32'h0C, 32'h0);
    apb_write(32'h18, 32'hFFFF_FFFF);
    apb_read(32'h18, rd); chk("unmapped", rd, 32'h0);

    // ---------------- basic route: CH0 on, src1 -> dst0 ----------------
    apb_write(32'h00, 32'h0000_0011);
    apb_read(32'h00, rd); chk("ch0_cfg", rd, 32'h0000_0011);
    @(negedge pclk); src_trig = 8'h02;
    tick();
    chk("a_on",  {28'h0, trig_en_on},  32'h1);
    chk("a_off", {28'h0, trig_en_off}, 32'h0);
    @(negedge pclk); src_trig = 8'h00;
    tick();
    chk("a_on_end", {28'h0, trig_en_on}, 32'h0);
    apb_read(32'h14, rd); chk("a_pend", rd, 32'h1);
    apb_write(32'h14, 32'h1);
    apb_read(32'h14, rd); chk("a_clr", rd, 32'h0);

    // ---------------- collision: CH0 on dst1, CH1 off dst1, src3 ----------------
    apb_write(32'h00, 32'h0000_0131);
    apb_write(32'h04, 32'h0000_0133);
    @(negedge pclk); src_trig = 8'h08;
    tick();
    chk("b_on",  {28'h0, trig_en_on},  32'h0);
    chk("b_off", {28'h0, trig_en_off}, 32'h2);
    @(negedge pclk); src_trig = 8'h00;
    apb_read(32'h14, rd); chk("b_stat", rd, 32'h0000_0103);
    apb_write(32'h14, 32'h0000_0F0F);
    apb_read(32'h14, rd); chk("b_clr", rd, 32'h0);
    apb_write(32'h00, 32'h0);
    apb_write(32'h04, 32'h0);

    // ---------------- held level: CH2 on, src2 -> dst2 ----------------
    apb_write(32'h08, 32'h0000_0221);
    @(negedge pclk); src_trig = 8'h04;
    tick();
    chk("c_first", {28'h0, trig_en_on}, 32'h4);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("c_held", {28'h0, trig_en_on}, 32'h0);
    end
    @(negedge pclk); src_trig = 8'h00;
    tick();
    chk("c_low", {28'h0, trig_en_on}, 32'h0);
    @(negedge pclk); src_trig = 8'h04;
    tick();
    chk("c_second", {28'h0, trig_en_on}, 32'h4);
    @(negedge pclk); src_trig = 8'h00;
    tick();
    chk("c_end", {28'h0, trig_en_on}, 32'h0);
    apb_write(32'h08, 32'h0);
    apb_write(32'h14, 32'h0000_0F0F);

    // ---------------- software trigger: CH0 enabled, CH3 disabled ----------------
    apb_write(32'h00, 32'h0000_0071);
    apb_write(32'h10, 32'h0000_0009);
    chk("d_on",  {28'h0, trig_en_on},  32'h1);
    chk("d_off", {28'h0, trig_en_off}, 32'h0);
    apb_read(32'h14, rd); chk("d_pend", rd, 32'h1);
    apb_read(32'h10, rd); chk("d_soft_rd", rd, 32'h0);
    tick();
    chk("d_on_end", {28'h0, trig_en_on}, 32'h0);
    apb_write(32'h14, 32'h1);
    apb_read(32'h14, rd); chk("d_clr", rd, 32'h0);

    // ---------------- set beats W1C, interrupt timing: CH1 src4 -> dst3 ----------------
    apb_write(32'h04, 32'h0001_0341);
    @(negedge pclk);
    psel = 1'b1; pwrite = 1'b1; penable = 1'b0; paddr = 32'h14; pwdata = 32'h2;
    @(negedge pclk);
    penable = 1'b1; src_trig = 8'h10;
    @(posedge pclk);
    #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    chk("e_on",   {28'h0, trig_en_on}, 32'h8);
    chk("e_intr0", {31'h0, intr},      32'h0);
    @(negedge pclk); src_trig = 8'h00;
    tick();
    chk("e_intr1", {31'h0, intr}, 32'h1);
    apb_read(32'h14, rd); chk("e_pend", rd, 32'h2);
    apb_write(32'h14, 32'h2);
    tick();
    chk("e_intr_clr", {31'h0, intr}, 32'h0);

    // ---------------- reset during an active pulse ----------------
    apb_write(32'h10, 32'h0000_0001);
    chk("f_on_pre", {28'h0, trig_en_on}, 32'h1);
    #2;
    preset = 1'b1;
    #1;
    chk("f_on_rst",   {28'h0, trig_en_on},  32'h0);
    chk("f_off_rst",  {28'h0, trig_en_off}, 32'h0);
    chk("f_intr_rst", {31'h0, intr},        32'h0);
    apb_read(32'h00, rd); chk("f_ch0_rst", rd, 32'h0);
    @(negedge pclk);
    preset = 1'b0;
    tick();
    chk("f_no_replay", {28'h0, trig_en_on}, 32'h0);
    apb_read(32'h14, rd); chk("f_stat", rd, 32'h0);
    apb_read(32'h04, rd); chk("f_ch1", rd, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
